// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - timing classes, base lengths and extension flags for the 6502 cycle sequencer
package cpu_pkg;

   typedef enum logic [4:0] {
      IMP, IMM, ZP, ZPX, ABS, ABSX_R, ABSX_W, INDX, INDY_R, INDY_W, REL,
      ZP_RMW, ZPX_RMW, ABS_RMW, ABSX_RMW, PUSH, PULL, JMP_ABS, JMP_IND,
      JSR, RTS, RTI, BRK, ILL
   } tclass_e;

   // Base instruction length in cycles, before any page-cross or branch extension.
   function automatic logic [2:0] cls_len(input tclass_e c);
      logic [2:0] n;
      case (c)
         IMP, IMM, REL, ILL:                          n = 3'd2;
         ZP, JMP_ABS, PUSH:                           n = 3'd3;
         ZPX, ABS, ABSX_R, PULL:                      n = 3'd4;
         INDY_R, ABSX_W, ZP_RMW, JMP_IND:             n = 3'd5;
         INDX, INDY_W, ZPX_RMW, ABS_RMW, JSR, RTS, RTI: n = 3'd6;
         ABSX_RMW, BRK:                               n = 3'd7;
         default:                                     n = 3'd2;
      endcase
      return n;
   endfunction

   // Classes whose length can grow by a page cross or a taken branch.
   function automatic logic cls_ext(input tclass_e c);
      return (c == ABSX_R) || (c == INDY_R) || (c == REL);
   endfunction

endpackage

// File: rtl/cpu_opclass_dec.sv
// rtl/cpu_opclass_dec.sv - combinational opcode to timing-class decode from the aaabbbcc fields
module cpu_opclass_dec
   import cpu_pkg::*;
(
   input  logic [7:0] ir,
   output tclass_e    tclass
);

   logic [2:0] aaa;
   logic [2:0] bbb;
   logic [1:0] cc;

   assign aaa = ir[7:5];
   assign bbb = ir[4:2];
   assign cc  = ir[1:0];

   // Field-based decode; anything not a documented opcode falls through to ILL.
   always_comb begin
      tclass = ILL;
      case (cc)
         2'b01: begin
            case (bbb)
               3'b000: tclass = INDX;
               3'b001: tclass = ZP;
               3'b010: tclass = (aaa == 3'b100) ? ILL : IMM;
               3'b011: tclass = ABS;
               3'b100: tclass = (aaa == 3'b100) ? INDY_W : INDY_R;
               3'b101: tclass = ZPX;
               default: tclass = (aaa == 3'b100) ? ABSX_W : ABSX_R;
            endcase
         end
         2'b10: begin
            if (aaa == 3'b100) begin
               case (bbb)
                  3'b001: tclass = ZP;
                  3'b011: tclass = ABS;
                  3'b101: tclass = ZPX;
                  3'b010, 3'b110: tclass = IMP;
                  default: tclass = ILL;
               endcase
            end else if (aaa == 3'b101) begin
               case (bbb)
                  3'b000: tclass = IMM;
                  3'b001: tclass = ZP;
                  3'b011: tclass = ABS;
                  3'b101: tclass = ZPX;
                  3'b111: tclass = ABSX_R;
                  3'b010, 3'b110: tclass = IMP;
                  default: tclass = ILL;
               endcase
            end else begin
               case (bbb)
                  3'b001: tclass = ZP_RMW;
                  3'b010: tclass = IMP;
                  3'b011: tclass = ABS_RMW;
                  3'b101: tclass = ZPX_RMW;
                  3'b111: tclass = ABSX_RMW;
                  default: tclass = ILL;
               endcase
            end
         end
         2'b00: begin
            case (bbb)
               3'b100: tclass = REL;
               3'b110: tclass = IMP;
               3'b010: begin
                  if (aaa[2]) tclass = IMP;
                  else        tclass = aaa[0] ? PULL : PUSH;
               end
               3'b000: begin
                  case (aaa)
                     3'b000: tclass = BRK;
                     3'b001: tclass = JSR;
                     3'b010: tclass = RTI;
                     3'b011: tclass = RTS;
                     3'b100: tclass = ILL;
                     default: tclass = IMM;
                  endcase
               end
               3'b001: tclass = ((aaa == 3'b001) || aaa[2]) ? ZP : ILL;
               3'b011: begin
                  case (aaa)
                     3'b000: tclass = ILL;
                     3'b010: tclass = JMP_ABS;
                     3'b011: tclass = JMP_IND;
                     default: tclass = ABS;
                  endcase
               end
               3'b101: tclass = ((aaa == 3'b100) || (aaa == 3'b101)) ? ZPX : ILL;
               default: tclass = (aaa == 3'b101) ? ABSX_R : ILL;
            endcase
         end
         default: tclass = ILL;
      endcase
   end

endmodule

// File: rtl/cpu_timing_gen.sv
// rtl/cpu_timing_gen.sv - 6502 cycle sequencer; CPU_TIMING_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module cpu_timing_gen
   import cpu_pkg::*;
#(
   parameter logic [2:0] RST_CYC = 3'd1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ir,
   input  logic       rdy,
   input  logic       page_cross,
   input  logic       branch_taken,
   output logic       sync,
   output logic [2:0] cyc,
   output logic       last,
   output logic [4:0] tclass,
   output logic       illegal
);

   tclass_e    dec_cls;
   tclass_e    cls;
   logic [2:0] cyc_q, cyc_d;
   logic       sync_q, sync_d;
   logic       last_q, last_d;
   logic [1:0] ext_q, ext_d;
   logic [3:0] base;
   logic [3:0] n_eff;
   logic       ext_now;
   logic       is_final;
   logic [2:0] cyc_inc;
   logic [1:0] ext_sum;

   cpu_opclass_dec u_dec (
      .ir     (ir),
      .tclass (dec_cls)
   );

`ifdef CPU_TIMING_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
   logic trap_hit;
   assign cls       = dec_cls;
   assign trap_hit  = (cyc_q == 3'd1) && (dec_cls == ILL);
   assign illegal   = illegal_q;
`else
   assign cls       = (dec_cls == ILL) ? IMP : dec_cls;
   assign illegal   = 1'b0;
`endif

   assign tclass = cls;
   assign cyc    = cyc_q;
   assign sync   = sync_q;
   assign last   = last_q;

   // Length of the running instruction including extensions granted so far and this cycle.
   always_comb begin
      base    = {1'b0, cls_len(cls)};
      ext_now = 1'b0;
      if (cls == REL) begin
         if ((cyc_q == 3'd1) && branch_taken)                  ext_now = 1'b1;
         if ((cyc_q == 3'd2) && (ext_q == 2'd1) && page_cross) ext_now = 1'b1;
      end else if (cls_ext(cls) && ({1'b0, cyc_q} == base - 4'd1) && page_cross) begin
         ext_now = 1'b1;
      end
      n_eff    = base + {2'b00, ext_q} + {3'b000, ext_now};
      // >= also retires out-of-range counts and counts stranded by an ir change.
      is_final = ({1'b0, cyc_q} >= n_eff - 4'd1);
      cyc_inc  = cyc_q + 3'd1;
      ext_sum  = ext_q + {1'b0, ext_now};
   end

   // Next-state: trap freeze, then rdy-gated advance or wrap to the opcode fetch.
   always_comb begin
      cyc_d  = cyc_q;
      sync_d = sync_q;
      last_d = last_q;
      ext_d  = ext_q;
`ifdef CPU_TIMING_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
      if (illegal_q || trap_hit) begin
         illegal_d = 1'b1;
         cyc_d     = 3'd1;
         sync_d    = 1'b0;
         last_d    = 1'b0;
         ext_d     = 2'd0;
      end else
`endif
      if (rdy) begin
         if (is_final) begin
            cyc_d  = 3'd0;
            sync_d = 1'b1;
            last_d = 1'b0;
            ext_d  = 2'd0;
         end else begin
            cyc_d  = cyc_inc;
            sync_d = 1'b0;
            ext_d  = ext_sum;
            // Predicted final cycle; a later extension keeps last high into the added cycle.
            last_d = ({1'b0, cyc_inc} == base + {2'b00, ext_sum} - 4'd1);
         end
      end
   end

   // State register with synchronous reset taking priority over rdy.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= RST_CYC;
         sync_q <= 1'b0;
         last_q <= 1'b0;
         ext_q  <= 2'd0;
`ifdef CPU_TIMING_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         cyc_q  <= cyc_d;
         sync_q <= sync_d;
         last_q <= last_d;
         ext_q  <= ext_d;
`ifdef CPU_TIMING_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

endmodule

// File: tb/tb_cpu_timing_gen.sv
// tb/tb_cpu_timing_gen.sv - scoreboard bench for cpu_timing_gen (CPU_TIMING_ILLEGAL_TRAP_EN aware)
module tb_cpu_timing_gen;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst, rdy, page_cross, branch_taken;
   logic [7:0] ir;
   logic       sync, last, illegal;
   logic [2:0] cyc;
   logic [4:0] tclass;

   typedef struct {
      logic [2:0] cyc;
      logic       sync;
      logic       last;
      logic       chk_last;
      logic       ill;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   cpu_timing_gen #(.RST_CYC(3'd1)) dut (
      .clk          (clk),
      .rst          (rst),
      .ir           (ir),
      .rdy          (rdy),
      .page_cross   (page_cross),
      .branch_taken (branch_taken),
      .sync         (sync),
      .cyc          (cyc),
      .last         (last),
      .tclass       (tclass),
      .illegal      (illegal)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input string tag, input logic [2:0] e_cyc, input logic e_sync,
                       input logic e_last, input logic chk_last, input logic e_ill);
      exp_t e;
      e.cyc = e_cyc; e.sync = e_sync; e.last = e_last; e.chk_last = chk_last; e.ill = e_ill;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_eq({tag, ".cyc"}, {29'd0, cyc}, {29'd0, e.cyc});
      check_eq({tag, ".sync"}, {31'd0, sync}, {31'd0, e.sync});
      check_eq({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
      if (e.chk_last) check_eq({tag, ".last"}, {31'd0, last}, {31'd0, e.last});
   endtask

   task automatic run_instr(input string tag, input logic [7:0] op, input int base, input int n_eff,
                            input logic ext_ok, input int c0, input logic [7:0] pc_mask,
                            input logic bt, input int stall_cyc, input int stall_n);
      int  nc;
      logic amb;
      ir = op;
      branch_taken = bt;
      for (int c = c0; c < n_eff; c++) begin
         if (c == stall_cyc) begin
            rdy = 1'b0;
            page_cross = 1'b1;
            branch_taken = 1'b1;
            for (int k = 0; k < stall_n; k++)
               tick({tag, ".hold"}, c[2:0], c == 0, c == n_eff - 1, !ext_ok, 1'b0);
            rdy = 1'b1;
            branch_taken = bt;
         end
         page_cross = pc_mask[c];
         nc  = (c == n_eff - 1) ? 0 : c + 1;
         amb = ext_ok && (nc >= base - 1) && (nc != n_eff - 1);
         tick(tag, nc[2:0], nc == 0, nc == n_eff - 1, !amb, 1'b0);
      end
      page_cross = 1'b0;
      branch_taken = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; page_cross = 1'b0; branch_taken = 1'b0;
      ir = 8'hA9; #1; check_eq("tclass_a9", {27'd0, tclass}, {27'd0, IMM});
      ir = 8'h9D; #1; check_eq("tclass_9d", {27'd0, tclass}, {27'd0, ABSX_W});
      ir = 8'hD0; #1; check_eq("tclass_d0", {27'd0, tclass}, {27'd0, REL});
`ifdef CPU_TIMING_ILLEGAL_TRAP_EN
      ir = 8'h02; #1; check_eq("tclass_02", {27'd0, tclass}, {27'd0, ILL});
`else
      ir = 8'h02; #1; check_eq("tclass_02", {27'd0, tclass}, {27'd0, IMP});
`endif
      ir = 8'h6C;
      tick("reset", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick("reset", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;

      // JMP ind resumes from cyc 1 after reset.
      run_instr("jmp_ind", 8'h6C, 5, 5, 1'b0, 1, 8'h00, 1'b0, -1, 0);
      // LDA # twice; page_cross ignored for a non-extendable class.
      run_instr("lda_imm", 8'hA9, 2, 2, 1'b0, 0, 8'h00, 1'b0, -1, 0);
      run_instr("lda_imm2", 8'hA9, 2, 2, 1'b0, 0, 8'hFF, 1'b0, -1, 0);
      // LDA abs,x: cross outside cyc 3 ignored, cross at cyc 3 adds one.
      run_instr("lda_absx", 8'hBD, 4, 4, 1'b1, 0, 8'h06, 1'b0, -1, 0);
      run_instr("lda_absx_pc", 8'hBD, 4, 5, 1'b1, 0, 8'h08, 1'b0, -1, 0);
      // STA abs,x never extends.
      run_instr("sta_absx", 8'h9D, 5, 5, 1'b0, 0, 8'hFF, 1'b0, -1, 0);
      // LDA (ind),y crossed at cyc 4.
      run_instr("lda_indy_pc", 8'hB1, 5, 6, 1'b1, 0, 8'h10, 1'b0, -1, 0);
      // BNE not taken, taken, taken with cross.
      run_instr("bne_nt", 8'hD0, 2, 2, 1'b1, 0, 8'hFF, 1'b0, -1, 0);
      run_instr("bne_t", 8'hD0, 2, 3, 1'b1, 0, 8'h00, 1'b1, -1, 0);
      run_instr("bne_tpc", 8'hD0, 2, 4, 1'b1, 0, 8'h04, 1'b1, -1, 0);
      // BRK with a 3-clock stall at cyc 2: 10 clocks overall.
      run_instr("brk_stall", 8'h00, 7, 7, 1'b0, 0, 8'h00, 1'b0, 2, 3);
      run_instr("jsr", 8'h20, 6, 6, 1'b0, 0, 8'h00, 1'b0, -1, 0);

      // ASL abs abandoned by reset at cyc 3.
      ir = 8'h0E;
      tick("asl_abs", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick("asl_abs", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      tick("asl_abs", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b1; ir = 8'h02;
      tick("mid_rst", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
`ifdef CPU_TIMING_ILLEGAL_TRAP_EN
      tick("trap", 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      rdy = 1'b0;
      tick("trap_nordy", 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      rdy = 1'b1; ir = 8'hEA;
      tick("trap_hold", 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      rst = 1'b1;
      tick("trap_rst", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      tick("after_trap", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
`else
      tick("ill_nop", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      run_instr("ill_nop2", 8'h02, 2, 2, 1'b0, 0, 8'h00, 1'b0, -1, 0);
`endif
      run_instr("final_nop", 8'hEA, 2, 2, 1'b0, 0, 8'h00, 1'b0, -1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_timing_gen.md
Name: cpu_timing_gen

Overview:
- 6502 cycle sequencer sitting directly downstream of the instruction register.
- Decodes the opcode the IR holds into a timing class and counts machine cycles within the instruction.
- Asserts sync for the opcode-fetch cycle so the IR captures the next opcode.
- Supplies the cycle number and timing class to the control/ALU sequencing logic.

Parameters:
- RST_CYC, 1, cycle number loaded at reset. 1 means execution starts on the opcode already in the IR; the IR resets to JMP ind (0x6C).

Ports:
- clk  in  1  CPU phase clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- ir  in  8  current opcode from the instruction register
- rdy  in  1  1 = advance; 0 = freeze all state this cycle
- page_cross  in  1  address carry into high byte; sampled only in the extension cycles defined below
- branch_taken  in  1  branch condition true; sampled only in cycle 1 of a relative-mode instruction
- sync  out  1  1 during the opcode-fetch cycle (cyc==0); registered
- cyc  out  3  current cycle within instruction, 0..6; registered
- last  out  1  1 in the final cycle of the instruction; registered
- tclass  out  5  timing class of ir; combinational decode, no reset of its own
- illegal  out  1  see Optional Feature

Behaviour:
- Reset (rst=1 at clk edge):
  - cyc=RST_CYC, sync=0, last=0, illegal=0, ext=0.
  - rst has priority over rdy.
  - Reset mid-instruction abandons the instruction with no residual state.
- Base length N per class:
  - 2 cycles: implied, accumulator, immediate, relative.
  - 3 cycles: zp, JMP abs, push.
  - 4 cycles: zp,x/y, abs, abs,x/y read, pull.
  - 5 cycles: (ind),y read, abs,x/y write, zp RMW, JMP ind.
  - 6 cycles: (ind,x), (ind),y write, zp,x RMW, abs RMW, JSR, RTS, RTI.
  - 7 cycles: abs,x RMW, BRK.
- Extensions (only when rdy=1):
  - abs,x/y read and (ind),y read: if page_cross=1 while cyc==N-1, one extra cycle is added.
  - Relative: branch_taken=1 at cyc==1 adds cycle 2. page_cross=1 at cyc==2 adds cycle 3.
  - Maximum length is 7. A relative branch therefore takes 2, 3 or 4 cycles.
  - Write and RMW classes never extend.
- Per edge with rdy=1:
  - If the current cycle is final (cyc==N_eff-1), then cyc<=0 and sync<=1.
  - Otherwise cyc<=cyc+1 and sync<=0.
  - last is registered so that it is high exactly when cyc==N_eff-1.
- rdy=0: cyc, sync, last, ext are all held. page_cross and branch_taken are ignored.
- tclass follows ir immediately. A new ir arriving during cyc 0 takes effect from cyc 1 onward.
- cyc never exceeds 6. An out-of-range state returns to cyc=0 with sync=1 on the next rdy edge.

Optional Feature:
- Macro: CPU_TIMING_ILLEGAL_TRAP_EN
- Without the macro:
  - Undocumented opcodes decode as class implied (2-cycle NOP).
  - illegal is tied to 0.
- With the macro:
  - An undocumented opcode reaching cyc 1 sets illegal=1.
  - cyc then freezes at 1 with sync=0 regardless of rdy.
  - Only rst clears the trap.

Decomposition:
- Package cpu_pkg:
  - tclass enum: IMP, IMM, ZP, ZPX, ABS, ABSX_R, ABSX_W, INDX, INDY_R, INDY_W, REL, ZP_RMW, ZPX_RMW, ABS_RMW, ABSX_RMW, PUSH, PULL, JMP_ABS, JMP_IND, JSR, RTS, RTI, BRK, ILL.
  - Constant function/table giving base length per class.
  - Flag marking extendable classes.
- Sub-module cpu_opclass_dec:
  - Purely combinational ir -> tclass.
  - Decode from the aaabbbcc opcode fields plus explicit exceptions.

Test Plan:
- Reset released with ir=0x6C → cyc sequence 1,2,3,4,0, with sync=1 only at cyc 0 and last=1 at cyc 4.
- ir=0xA9 (LDA #) → 2 cycles; sync pulses every second clock.
- ir=0xBD (LDA abs,x), page_cross=0 at cyc 3 → 4 cycles; page_cross=1 at cyc 3 → 5 cycles, last at cyc 4.
- ir=0xD0 (BNE): branch_taken=0 → 2 cycles; taken with no cross → 3 cycles; taken with cross → 4 cycles.
- ir=0x00 (BRK) with rdy=0 for 3 clocks at cyc 2 → cyc held at 2, instruction completes 10 clocks after start.
- ir=0x02 with rst asserted at cyc 1:
  - Macro off: 2-cycle NOP, illegal=0.
  - Macro on: illegal=1 and cyc stuck at 1 until rst; after rst, cyc=1, illegal=0.
